// File: rtl/elem_ca.sv
// ---------------------------------------------------------------------------
// elem_ca : one-dimensional elementary cellular automaton with run/step control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module elem_ca #(
  parameter int WIDTH = 512,
  parameter int CNT_W = 16,
  parameter int GEN_W = 32
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_rule;
  logic             r_wrap;
  logic [CNT_W-1:0] r_left;
  logic [WIDTH-1:0] r_q;
  logic [GEN_W-1:0] r_gen;
  logic             r_done;

  logic             w_accept;
  logic             w_apply;
  logic             w_done_nxt;
  logic             w_last;
  logic [7:0]       w_rule_sel;
  logic             w_wrap_sel;
  logic [WIDTH-1:0] w_lft;
  logic [WIDTH-1:0] w_rgt;
  logic [WIDTH-1:0] w_next;

  // A run uses the settings latched at start; a single step uses the live inputs.
  assign w_rule_sel = (r_state == RUN) ? r_rule : rule;
  assign w_wrap_sel = (r_state == RUN) ? r_wrap : wrap;

  assign w_lft = {(w_wrap_sel ? r_q[0] : 1'b0), r_q[WIDTH-1:1]};
  assign w_rgt = {r_q[WIDTH-2:0], (w_wrap_sel ? r_q[WIDTH-1] : 1'b0)};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_next[i] = w_rule_sel[{w_lft[i], r_q[i], w_rgt[i]}];
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    w_done_nxt  = 1'b0;
    w_last      = (r_left == CNT_W'(1));
    if (load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_accept = 1'b1;
            if (count == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = RUN;
            end
          end else if (step) begin
            w_apply = 1'b1;
          end
        end
        RUN: begin
          w_apply = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_q    <= '0;
      r_gen  <= '0;
      r_done <= 1'b0;
      r_rule <= '0;
      r_wrap <= 1'b0;
      r_left <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (load) begin
        r_q    <= data;
        r_gen  <= '0;
        r_left <= '0;
      end else begin
        if (w_accept) begin
          r_rule <= rule;
          r_wrap <= wrap;
          r_left <= count;
        end else if (r_state == RUN) begin
          r_left <= r_left - CNT_W'(1);
        end
        if (w_apply) begin
          r_q   <= w_next;
          r_gen <= r_gen + GEN_W'(1);
        end
      end
    end
  end

  assign q    = r_q;
  assign busy = (r_state == RUN);
  assign done = r_done;
  assign gen  = r_gen;

endmodule

`default_nettype wire

// File: tb/tb_elem_ca.sv
// ---------------------------------------------------------------------------
// tb_elem_ca : directed bench for elem_ca with a cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_elem_ca;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        load;
  logic [15:0] data;
  logic [7:0]  rule;
  logic        wrap;
  logic        start;
  logic [7:0]  count;
  logic        step;
  logic [15:0] q;
  logic        busy;
  logic        done;
  logic [3:0]  gen;

  int vectors    = 0;
  int miscompares = 0;

  elem_ca #(.WIDTH(16), .CNT_W(8), .GEN_W(4)) dut (
    .clk(clk), .areset_n(areset_n), .load(load), .data(data), .rule(rule),
    .wrap(wrap), .start(start), .count(count), .step(step),
    .q(q), .busy(busy), .done(done), .gen(gen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next generation straight from the rule table, cell by cell.
  function automatic logic [15:0] ca_next(input logic [15:0] s, input logic [7:0] r, input logic w);
    logic [15:0] n;
    int l, c, rr;
    for (int i = 0; i < 16; i++) begin
      c  = int'(s[i]);
      l  = (i == 15) ? (w ? int'(s[0]) : 0) : int'(s[i+1]);
      rr = (i == 0) ? (w ? int'(s[15]) : 0) : int'(s[i-1]);
      n[i] = r[l*4 + c*2 + rr];
    end
    return n;
  endfunction

  logic [15:0] mq;
  logic [3:0]  mgen;
  logic        mbusy, mdone, mwrap;
  logic [7:0]  mrule;
  int          mleft;

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mq = '0; mgen = '0; mbusy = 1'b0; mdone = 1'b0; mleft = 0;
    end else begin
      mdone = 1'b0;
      if (load) begin
        mq = data; mgen = '0; mbusy = 1'b0; mleft = 0;
      end else if (mbusy) begin
        mq = ca_next(mq, mrule, mwrap);
        mgen = mgen + 4'd1;
        mleft = mleft - 1;
        if (mleft == 0) begin
          mbusy = 1'b0; mdone = 1'b1;
        end
      end else if (start) begin
        mrule = rule; mwrap = wrap;
        if (count == 8'd0) mdone = 1'b1;
        else begin mbusy = 1'b1; mleft = int'(count); end
      end else if (step) begin
        mq = ca_next(mq, rule, wrap);
        mgen = mgen + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (areset_n) begin
      chk("model_q", 32'(q), 32'(mq));
      chk("model_gen", 32'(gen), 32'(mgen));
      chk("model_busy", 32'(busy), 32'(mbusy));
      chk("model_done", 32'(done), 32'(mdone));
    end
  end

  task automatic do_load(input logic [15:0] d);
    load = 1'b1; data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] r, input logic w, input logic [7:0] c);
    rule = r; wrap = w; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step(input logic [7:0] r, input logic w);
    rule = r; wrap = w; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  int nb, nd;

  initial begin
    areset_n = 1'b0; load = 1'b0; data = '0; rule = '0; wrap = 1'b0;
    start = 1'b0; count = '0; step = 1'b0;
    #12;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_busy_done_gen", {busy, done, gen}, 32'h0);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);

    // Rule 90, single-generation run
    do_load(16'h0100);
    pulse_start(8'd90, 1'b0, 8'd1);
    chk("run1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("run1_q", 32'(q), 32'h0280);
    chk("run1_gen", 32'(gen), 32'h1);
    chk("run1_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("run1_done_drop", 32'(done), 32'h0);

    // Boundaries
    do_load(16'h0001);
    pulse_step(8'd90, 1'b1);
    chk("wrap1_q", 32'(q), 32'h8002);
    chk("step_no_done", 32'(done), 32'h0);
    do_load(16'h0001);
    pulse_step(8'd90, 1'b0);
    chk("wrap0_q", 32'(q), 32'h0002);

    // Rule 30, then rule change mid-run is ignored
    do_load(16'h0100);
    pulse_start(8'd30, 1'b0, 8'd1);
    @(negedge clk);
    chk("rule30_q", 32'(q), 32'h0380);
    do_load(16'h0100);
    pulse_start(8'd30, 1'b0, 8'd3);
    rule = 8'd90; wrap = 1'b1; count = 8'd7;
    repeat (3) @(negedge clk);
    chk("rule30x3_q", 32'(q), 32'h0DE0);
    chk("rule30x3_done", 32'(done), 32'h1);

    // Run timing with start/step pressed while busy
    do_load(16'h0100);
    pulse_start(8'd30, 1'b0, 8'd3);
    nb = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin start = 1'b1; step = 1'b1; rule = 8'd90; count = 8'd9; end
      if (i == 1) begin start = 1'b0; step = 1'b0; end
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    chk("run3_busy_cycles", 32'(nb), 32'd3);
    chk("run3_done_pulses", 32'(nd), 32'd1);
    chk("run3_gen", 32'(gen), 32'h3);
    chk("run3_q", 32'(q), 32'h0DE0);
    pulse_start(8'd30, 1'b0, 8'd0);
    chk("cnt0_done", 32'(done), 32'h1);
    chk("cnt0_busy", 32'(busy), 32'h0);
    chk("cnt0_gen_q", {12'h0, gen, q}, {12'h0, 4'h3, 16'h0DE0});

    // Back-to-back: start accepted during the done cycle
    @(negedge clk);
    pulse_start(8'd90, 1'b0, 8'd1);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'h1);
    pulse_start(8'd90, 1'b0, 8'd1);
    chk("b2b_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("b2b_gen", 32'(gen), 32'h5);

    // Start beats step; load beats start
    rule = 8'd90; count = 8'd2; start = 1'b1; step = 1'b1;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    chk("start_over_step", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    load = 1'b1; data = 16'h1234; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("load_over_start", {15'h0, busy, q}, {15'h0, 1'b0, 16'h1234});

    // Load aborts a run without done
    do_load(16'h0100);
    pulse_start(8'd30, 1'b0, 8'd5);
    repeat (2) @(negedge clk);
    do_load(16'hA5A5);
    chk("abort_q", 32'(q), 32'hA5A5);
    chk("abort_gen_busy", {gen, busy}, 32'h0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // Asynchronous reset mid-run
    do_load(16'h0100);
    pulse_start(8'd30, 1'b0, 8'd5);
    @(negedge clk);
    #2 areset_n = 1'b0;
    #1 chk("areset_q", 32'(q), 32'h0);
    chk("areset_ctl", {busy, done, gen}, 32'h0);
    @(negedge clk);
    areset_n = 1'b1;

    // Generation counter wraps at 2^4
    do_load(16'h0003);
    repeat (17) pulse_step(8'd90, 1'b0);
    chk("gen_wrap", 32'(gen), 32'h1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
